// File: rtl/axi_lite_param_slave.sv
// AXI4-Lite register slave: NUM_REGS registers with per-register read-only mask,
// decoupled AW/W capture buffers and a single outstanding B and R response.

module axi_lite_param_reg #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    we,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  output logic [DATA_WIDTH-1:0]   q
);
  localparam int NB = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    for (int b = 0; b < NB; b++)
      if (we && wstrb[b]) q_d[b*8 +: 8] = wdata[b*8 +: 8];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) q_q <= RESET_VAL;
    else        q_q <= q_d;
  end

  assign q = q_q;
endmodule

module axi_lite_param_slave #(
  parameter int                    ADDR_WIDTH = 6,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    NUM_REGS   = 8,
  parameter logic [NUM_REGS-1:0]   RO_MASK    = NUM_REGS'('h80),
  parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
  input  logic                    ACLK,
  input  logic                    ARESETn,
  input  logic [ADDR_WIDTH-1:0]   AWADDR,
  input  logic                    AWVALID,
  output logic                    AWREADY,
  input  logic [DATA_WIDTH-1:0]   WDATA,
  input  logic [DATA_WIDTH/8-1:0] WSTRB,
  input  logic                    WVALID,
  output logic                    WREADY,
  output logic [1:0]              BRESP,
  output logic                    BVALID,
  input  logic                    BREADY,
  input  logic [ADDR_WIDTH-1:0]   ARADDR,
  input  logic                    ARVALID,
  output logic                    ARREADY,
  output logic [DATA_WIDTH-1:0]   RDATA,
  output logic [1:0]              RRESP,
  output logic                    RVALID,
  input  logic                    RREADY
);
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int OFFS   = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(NUM_REGS);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
  } aw_req_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [STRB_W-1:0]     strb;
  } w_req_t;

  typedef struct packed {
    logic [1:0]            resp;
    logic [DATA_WIDTH-1:0] data;
  } r_rsp_t;

  aw_req_t aw_q, aw_d;
  w_req_t  w_q, w_d;
  r_rsp_t  r_q, r_d;
  logic    aw_full_q, aw_full_d, w_full_q, w_full_d;
  logic    awready_q, awready_d, wready_q, wready_d;
  logic    bvalid_q, bvalid_d;
  logic    [1:0] bresp_q, bresp_d;
  logic    arready_q, arready_d, rvalid_q, rvalid_d;

  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs;
  logic [NUM_REGS-1:0]                 reg_we;

  logic [31:0]      wr_idx, rd_idx;
  logic [IDX_W-1:0] wr_sel, rd_sel;
  logic [1:0]       wr_resp;
  logic             aw_hs, w_hs, b_hs, ar_hs, r_hs, commit;

  assign aw_hs  = awready_q && AWVALID;
  assign w_hs   = wready_q  && WVALID;
  assign b_hs   = bvalid_q  && BREADY;
  assign ar_hs  = arready_q && ARVALID;
  assign r_hs   = rvalid_q  && RREADY;
  // A pending B response blocks the next commit; the buffers may still fill.
  assign commit = aw_full_q && w_full_q && !bvalid_q;

  // Low offset bits are dropped, so unaligned addresses hit the enclosing word.
  assign wr_idx = 32'(aw_q.addr >> OFFS);
  assign rd_idx = 32'(ARADDR >> OFFS);
  assign wr_sel = wr_idx[IDX_W-1:0];
  assign rd_sel = rd_idx[IDX_W-1:0];

  always_comb begin
    wr_resp = RESP_OKAY;
    if (wr_idx >= NUM_REGS)  wr_resp = RESP_DECERR;
    else if (RO_MASK[wr_sel]) wr_resp = RESP_SLVERR;
  end

  always_comb begin
    reg_we = '0;
    if (commit && wr_resp == RESP_OKAY) reg_we[wr_sel] = 1'b1;
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
    axi_lite_param_reg #(
      .DATA_WIDTH (DATA_WIDTH),
      .RESET_VAL  (RESET_VAL)
    ) u_reg (
      .clk   (ACLK),
      .rst_n (ARESETn),
      .we    (reg_we[g]),
      .wdata (w_q.data),
      .wstrb (w_q.strb),
      .q     (regs[g])
    );
  end

  always_comb begin
    aw_d      = aw_q;
    aw_full_d = aw_full_q;
    w_d       = w_q;
    w_full_d  = w_full_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    rvalid_d  = rvalid_q;
    r_d       = r_q;

    if (commit) begin
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = wr_resp;
    end else if (b_hs) begin
      bvalid_d  = 1'b0;
    end

    if (aw_hs) begin
      aw_full_d = 1'b1;
      aw_d.addr = AWADDR;
    end
    if (w_hs) begin
      w_full_d  = 1'b1;
      w_d.data  = WDATA;
      w_d.strb  = WSTRB;
    end

    // Reads sample the register outputs before any same-edge commit lands.
    if (ar_hs) begin
      rvalid_d = 1'b1;
      if (rd_idx >= NUM_REGS) begin
        r_d.resp = RESP_DECERR;
        r_d.data = '0;
      end else begin
        r_d.resp = RESP_OKAY;
        r_d.data = regs[rd_sel];
      end
    end else if (r_hs) begin
      rvalid_d = 1'b0;
    end

    awready_d = !aw_full_d;
    wready_d  = !w_full_d;
    arready_d = !rvalid_d;
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      aw_q      <= '0;
      aw_full_q <= 1'b0;
      w_q       <= '0;
      w_full_q  <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      r_q       <= '0;
    end else begin
      aw_q      <= aw_d;
      aw_full_q <= aw_full_d;
      w_q       <= w_d;
      w_full_q  <= w_full_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      r_q       <= r_d;
    end
  end

  assign AWREADY = awready_q;
  assign WREADY  = wready_q;
  assign BVALID  = bvalid_q;
  assign BRESP   = bresp_q;
  assign ARREADY = arready_q;
  assign RVALID  = rvalid_q;
  assign RDATA   = r_q.data;
  assign RRESP   = r_q.resp;
endmodule

// File: tb/tb_axi_lite_param_slave.sv
// Directed bench for axi_lite_param_slave: a transaction-level register model
// predicts every B/R response, checked each cycle by a monitor process.

module tb_axi_lite_param_slave;
  localparam int AW = 6, DW = 32, NR = 8;
  localparam logic [7:0] RO = 8'h80;

  logic          ACLK = 1'b0, ARESETn = 1'b0;
  logic [AW-1:0] AWADDR = '0, ARADDR = '0;
  logic          AWVALID = 1'b0, WVALID = 1'b0, ARVALID = 1'b0;
  logic          BREADY = 1'b1, RREADY = 1'b1;
  logic [DW-1:0] WDATA = '0;
  logic [3:0]    WSTRB = '0;
  logic          AWREADY, WREADY, BVALID, ARREADY, RVALID;
  logic [1:0]    BRESP, RRESP;
  logic [DW-1:0] RDATA;

  axi_lite_param_slave #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR), .RO_MASK(RO), .RESET_VAL('0)
  ) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
  );

  always #5 ACLK = ~ACLK;

  int tests = 0, fails = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: register file plus queues of predicted responses.
  typedef struct { logic [31:0] d; logic [1:0] r; } rexp_t;
  logic [31:0] mreg [NR];
  logic [1:0]  bq [$];
  rexp_t       rq [$];

  function automatic logic [1:0] m_resp(logic [AW-1:0] a, bit wr);
    int i = int'(a) / 4;
    if (i >= NR) return 2'b11;
    if (wr && RO[i]) return 2'b10;
    return 2'b00;
  endfunction

  task automatic m_write(logic [AW-1:0] a, logic [31:0] d, logic [3:0] s);
    logic [1:0] r = m_resp(a, 1'b1);
    bq.push_back(r);
    if (r == 2'b00)
      for (int b = 0; b < 4; b++) if (s[b]) mreg[int'(a) / 4][b*8 +: 8] = d[b*8 +: 8];
  endtask

  task automatic m_read(logic [AW-1:0] a);
    rexp_t e;
    e.r = m_resp(a, 1'b0);
    e.d = (e.r == 2'b11) ? 32'h0 : mreg[int'(a) / 4];
    rq.push_back(e);
  endtask

  task automatic m_reset();
    bq.delete();
    rq.delete();
    for (int i = 0; i < NR; i++) mreg[i] = '0;
  endtask

  // Monitor: every valid response must match the head of the model queue.
  bit mon = 0, live = 0;
  always @(posedge ACLK) live <= ARESETn;

  always @(negedge ACLK) begin
    if (mon) begin
      if (BVALID) begin
        if (bq.size() == 0) check("b_unexpected", BVALID, 1'b0);
        else begin
          check("mon_bresp", BRESP, bq[0]);
          if (BREADY) void'(bq.pop_front());
        end
      end
      if (RVALID) begin
        if (rq.size() == 0) check("r_unexpected", RVALID, 1'b0);
        else begin
          check("mon_rdata", RDATA, rq[0].d);
          check("mon_rresp", RRESP, rq[0].r);
          if (RREADY) void'(rq.pop_front());
        end
      end
      if (live) check("mon_arready", ARREADY, !RVALID);
    end
  end

  // Drivers: entered and left #1 after a rising edge.
  task automatic send_aw(logic [AW-1:0] a);
    int n = 0;
    AWADDR = a; AWVALID = 1'b1;
    @(negedge ACLK);
    while (!AWREADY && n < 50) begin @(negedge ACLK); n++; end
    if (!AWREADY) check("aw_timeout", AWREADY, 1'b1);
    @(posedge ACLK); #1 AWVALID = 1'b0;
  endtask

  task automatic send_w(logic [31:0] d, logic [3:0] s);
    int n = 0;
    WDATA = d; WSTRB = s; WVALID = 1'b1;
    @(negedge ACLK);
    while (!WREADY && n < 50) begin @(negedge ACLK); n++; end
    if (!WREADY) check("w_timeout", WREADY, 1'b1);
    @(posedge ACLK); #1 WVALID = 1'b0;
  endtask

  task automatic send_ar(logic [AW-1:0] a);
    int n = 0;
    ARADDR = a; ARVALID = 1'b1;
    @(negedge ACLK);
    while (!ARREADY && n < 50) begin @(negedge ACLK); n++; end
    if (!ARREADY) check("ar_timeout", ARREADY, 1'b1);
    @(posedge ACLK); #1 ARVALID = 1'b0;
  endtask

  task automatic wait_b(output logic [1:0] r);
    int n = 0;
    @(negedge ACLK);
    while (!(BVALID && BREADY) && n < 50) begin @(negedge ACLK); n++; end
    if (!BVALID) check("b_timeout", BVALID, 1'b1);
    r = BRESP;
    @(posedge ACLK); #1;
  endtask

  task automatic wait_r(output logic [31:0] d, output logic [1:0] r);
    int n = 0;
    @(negedge ACLK);
    while (!(RVALID && RREADY) && n < 50) begin @(negedge ACLK); n++; end
    if (!RVALID) check("r_timeout", RVALID, 1'b1);
    d = RDATA; r = RRESP;
    @(posedge ACLK); #1;
  endtask

  task automatic write(logic [AW-1:0] a, logic [31:0] d, logic [3:0] s, output logic [1:0] r);
    m_write(a, d, s);
    fork
      send_aw(a);
      send_w(d, s);
    join
    wait_b(r);
  endtask

  task automatic read(logic [AW-1:0] a, output logic [31:0] d, output logic [1:0] r);
    m_read(a);
    send_ar(a);
    wait_r(d, r);
  endtask

  logic [31:0] d;
  logic [1:0]  r;

  initial begin
    m_reset();
    repeat (3) @(posedge ACLK);
    #1;
    check("rst_awready", AWREADY, 0); check("rst_wready", WREADY, 0);
    check("rst_arready", ARREADY, 0); check("rst_bvalid", BVALID, 0);
    check("rst_rvalid", RVALID, 0);   check("rst_bresp", BRESP, 0);
    check("rst_rresp", RRESP, 0);     check("rst_rdata", RDATA, 0);
    ARESETn = 1'b1;
    @(posedge ACLK); #1;
    check("rel_awready", AWREADY, 1); check("rel_wready", WREADY, 1);
    check("rel_arready", ARREADY, 1);
    mon = 1;

    read(6'h00, d, r);
    check("rd00_data", d, 32'h0); check("rd00_resp", r, 2'b00);

    // W arrives three cycles ahead of AW.
    m_write(6'h08, 32'hDEADBEEF, 4'hF);
    send_w(32'hDEADBEEF, 4'hF);
    repeat (3) begin
      @(negedge ACLK);
      check("wfirst_wready", WREADY, 0); check("wfirst_bvalid", BVALID, 0);
    end
    @(posedge ACLK); #1;
    send_aw(6'h08);
    wait_b(r);
    check("wfirst_bresp", r, 2'b00);
    read(6'h08, d, r);
    check("rd08_data", d, 32'hDEADBEEF);

    write(6'h0A, 32'h11223344, 4'h5, r);
    check("strb_bresp", r, 2'b00);
    read(6'h08, d, r);
    check("strb_data", d, 32'hDE22BE44);

    // AW arrives ahead of W.
    m_write(6'h04, 32'hA5A50001, 4'hF);
    send_aw(6'h04);
    @(negedge ACLK);
    check("awfirst_awready", AWREADY, 0); check("awfirst_bvalid", BVALID, 0);
    @(posedge ACLK); #1;
    send_w(32'hA5A50001, 4'hF);
    wait_b(r);
    read(6'h04, d, r);
    check("rd04_data", d, 32'hA5A50001);

    write(6'h1C, 32'h12345678, 4'hF, r);
    check("ro_bresp", r, 2'b10);
    read(6'h1C, d, r);
    check("ro_data", d, 32'h0); check("ro_rresp", r, 2'b00);
    read(6'h24, d, r);
    check("dec_rdata", d, 32'h0); check("dec_rresp", r, 2'b11);
    write(6'h30, 32'hFFFFFFFF, 4'hF, r);
    check("dec_bresp", r, 2'b11);
    for (int i = 0; i < NR; i++) read(AW'(i * 4), d, r);
    read(6'h0B, d, r);
    check("unaligned_rd", d, 32'hDE22BE44);

    // Back-pressured B: second write buffers but cannot commit until B drains.
    BREADY = 1'b0;
    m_write(6'h0C, 32'hCAFEF00D, 4'hF);
    fork send_aw(6'h0C); send_w(32'hCAFEF00D, 4'hF); join
    repeat (2) @(posedge ACLK);
    #1;
    repeat (5) begin
      @(negedge ACLK);
      check("bstall_bvalid", BVALID, 1); check("bstall_bresp", BRESP, 2'b00);
    end
    @(posedge ACLK); #1;
    m_write(6'h10, 32'h0BADF00D, 4'h3);
    fork send_aw(6'h10); send_w(32'h0BADF00D, 4'h3); join
    @(negedge ACLK);
    check("bstall_awready", AWREADY, 0); check("bstall_wready", WREADY, 0);
    check("bstall_hold", BVALID, 1);
    @(posedge ACLK); #1 BREADY = 1'b1;
    @(posedge ACLK);
    @(negedge ACLK);
    check("bgap_bvalid", BVALID, 0); check("bgap_awready", AWREADY, 0);
    @(negedge ACLK);
    check("b2_bvalid", BVALID, 1); check("b2_bresp", BRESP, 2'b00);
    check("b2_awready", AWREADY, 1); check("b2_wready", WREADY, 1);
    @(posedge ACLK); #1;
    read(6'h0C, d, r); check("rd0c_data", d, 32'hCAFEF00D);
    read(6'h10, d, r); check("rd10_data", d, 32'h0000F00D);

    // Read and commit to the same register on the same edge.
    m_read(6'h0C);
    m_write(6'h0C, 32'h5555AAAA, 4'hF);
    AWADDR = 6'h0C; AWVALID = 1'b1; WDATA = 32'h5555AAAA; WSTRB = 4'hF; WVALID = 1'b1;
    @(posedge ACLK); #1;
    AWVALID = 1'b0; WVALID = 1'b0; ARADDR = 6'h0C; ARVALID = 1'b1;
    @(posedge ACLK); #1 ARVALID = 1'b0;
    @(negedge ACLK);
    check("same_edge_rdata", RDATA, 32'hCAFEF00D); check("same_edge_bvalid", BVALID, 1);
    repeat (2) @(posedge ACLK);
    #1;
    read(6'h0C, d, r); check("same_edge_after", d, 32'h5555AAAA);

    // Reset with AW buffered and an R response outstanding.
    RREADY = 1'b0;
    m_read(6'h0C);
    send_ar(6'h0C);
    send_aw(6'h14);
    @(negedge ACLK);
    check("pre_rst_rvalid", RVALID, 1); check("pre_rst_awready", AWREADY, 0);
    @(posedge ACLK); #1 ARESETn = 1'b0;
    @(posedge ACLK); #1 ARESETn = 1'b1;
    m_reset();
    @(negedge ACLK);
    check("mid_rst_rvalid", RVALID, 0); check("mid_rst_rdata", RDATA, 0);
    check("mid_rst_arready", ARREADY, 0); check("mid_rst_awready", AWREADY, 0);
    check("mid_rst_bvalid", BVALID, 0);
    RREADY = 1'b1;
    repeat (6) begin @(negedge ACLK); check("post_rst_nob", BVALID, 0); end
    @(posedge ACLK); #1;
    read(6'h0C, d, r); check("post_rst_rd0c", d, 32'h0);
    read(6'h08, d, r); check("post_rst_rd08", d, 32'h0);

    repeat (3) @(posedge ACLK);
    check("bq_drained", bq.size(), 0);
    check("rq_drained", rq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/axi_lite_param_slave.md
AXI_LITE_PARAM_SLAVE -- requirements
Module: axi_lite_param_slave

Interface
REQ-001 The block SHALL use one clock, ACLK; reset SHALL be ARESETn, synchronous and active-low.
REQ-002 ADDR_WIDTH, 6, byte-address width of AWADDR/ARADDR.
REQ-003 DATA_WIDTH, 32, data width; legal values SHALL be 32 or 64.
REQ-004 NUM_REGS, 8, register count; SHALL be a power of 2, >=2, and <= 2^ADDR_WIDTH/(DATA_WIDTH/8).
REQ-005 RO_MASK, 8'h80, NUM_REGS-bit mask; bit i=1 makes register i read-only.
REQ-006 RESET_VAL, 0, DATA_WIDTH-bit value loaded into every register at reset.
REQ-007 ACLK  in  1  clock, all logic on rising edge.
REQ-008 ARESETn  in  1  synchronous active-low reset.
REQ-009 AWADDR  in  ADDR_WIDTH  write byte address; AWVALID in 1; AWREADY out 1.
REQ-010 WDATA  in  DATA_WIDTH  write data; WSTRB in DATA_WIDTH/8 byte enables; WVALID in 1; WREADY out 1.
REQ-011 BRESP  out  2  write response; BVALID out 1; BREADY in 1.
REQ-012 ARADDR  in  ADDR_WIDTH  read byte address; ARVALID in 1; ARREADY out 1.
REQ-013 RDATA  out  DATA_WIDTH  read data; RRESP out 2; RVALID out 1; RREADY in 1.

Function
REQ-014 Register index SHALL be addr >> log2(DATA_WIDTH/8); low offset bits ignored (unaligned accesses act as aligned).
REQ-015 Response codes: OKAY=00 (valid index, writable or read), SLVERR=10 (write to RO register), DECERR=11 (index >= NUM_REGS).
REQ-016 AW and W SHALL be captured independently into separate one-entry buffers; AWREADY = AW buffer empty, WREADY = W buffer empty; order of AW vs W arrival SHALL not matter.
REQ-017 Handshake = VALID && READY at a rising edge; the buffer fills at that edge and its READY deasserts from that edge.
REQ-018 Commit: at the first edge where both buffers are full and BVALID=0, the write SHALL apply (OKAY only, per-byte by WSTRB), BVALID=1 and BRESP set, both buffers cleared (AWREADY/WREADY high after that edge).
REQ-019 SLVERR/DECERR writes SHALL change no register.
REQ-020 BVALID/BRESP SHALL hold stable until the edge with BVALID && BREADY, then BVALID=0; no new commit while BVALID=1 (buffers may still fill).
REQ-021 Read: ARREADY SHALL be high iff RVALID=0 (registered); AR handshake at edge t SHALL set RVALID=1, RDATA, RRESP at edge t and drop ARREADY.
REQ-022 RDATA SHALL be 0 for DECERR; RO registers read normally with OKAY.
REQ-023 RVALID/RDATA/RRESP SHALL hold stable until the edge with RVALID && RREADY; RVALID=0 and ARREADY=1 from that edge.
REQ-024 Read and commit to the same register at the same edge: read SHALL return the pre-write value.
REQ-025 Read and write channels SHALL operate concurrently and independently.

Reset
REQ-026 ARESETn=0 at an edge SHALL set all registers to RESET_VAL, clear both write buffers, and drive AWREADY=WREADY=ARREADY=BVALID=RVALID=0, BRESP=RRESP=00, RDATA=0.
REQ-027 First edge with ARESETn=1 SHALL raise AWREADY, WREADY, ARREADY.
REQ-028 Reset mid-transaction SHALL discard all buffered/pending transactions without a response.

Verification (defaults: DATA_WIDTH=32, NUM_REGS=8, ADDR_WIDTH=6, RO_MASK=8'h80)
REQ-029 Reset then read 0x00 -> RDATA=0x00000000, RRESP=00; all READYs 1 one cycle after release.
REQ-030 W (0xDEADBEEF, WSTRB=0xF) 3 cycles before AW 0x08 -> WREADY low while waiting, BRESP=00; read 0x08 -> 0xDEADBEEF.
REQ-031 Reg2=0xDEADBEEF, write 0x11223344 WSTRB=0x5 to 0x0A -> BRESP=00; read 0x08 -> 0xDE22BE44.
REQ-032 Write 0x12345678 to 0x1C -> BRESP=10; read 0x1C -> 0x00000000, RRESP=00. Read 0x24 -> RDATA=0, RRESP=11; write 0x30 -> BRESP=11, all registers unchanged.
REQ-033 BREADY low 5 cycles after commit -> BVALID/BRESP stable; second AW/W accepted, then AWREADY=WREADY=0 until B handshake; second commit on the following edge.
REQ-034 ARESETn low for one edge with AW buffered and RVALID=1 -> all outputs at reset values, no BVALID ever issued for the discarded write.
